// File: rtl/count_ctrl.sv
// count_ctrl: CE/UP/SCLR sequencer for the 8-bit up/down counter with internal step tick and shadow count.
// Define COUNT_CTRL_DWELL_EN to hold 2 ticks at each bounce/triangle turnaround.
module count_ctrl #(
    parameter int TICK_DIV = 5000000
) (
    input  logic       clk_5MHz,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [7:0] hi,
    output logic       cnt_ce,
    output logic       cnt_up,
    output logic       cnt_sclr,
    output logic [7:0] count,
    output logic       tick,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int DW = $clog2(TICK_DIV);
    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
    state_t        state;
    logic [DW-1:0] div;
    logic [1:0]    mode_q;
    logic [7:0]    hi_q;
    logic          dir, next_dir, wrap, fin, hold;

    // bounce reverses at both ends, triangle only at hi; up-only modes keep dir=1
    assign next_dir = !mode_q[1] ? dir : (count == hi_q) ? 1'b0 : (count == 8'd0 && !mode_q[0]) ? 1'b1 : dir;
    assign wrap = mode_q == 2'b01 && count == hi_q;
    assign fin = cnt_ce && (cnt_up ? mode_q == 2'b00 && count + 8'd1 == hi_q : mode_q == 2'b11 && count == 8'd1);

`ifdef COUNT_CTRL_DWELL_EN
    logic [1:0] dwell;
    assign hold = mode_q[1] && next_dir != dir && dwell != 2'd2;
    always_ff @(posedge clk_5MHz or posedge reset) begin
        if (reset)
            dwell <= 2'd0;
        else if (state == CLR)
            dwell <= 2'd0;
        else if (state == RUN && tick && !stop)
            dwell <= hold ? dwell + 2'd1 : 2'd0;
    end
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk_5MHz or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div      <= '0;
            mode_q   <= 2'b00;
            hi_q     <= 8'd0;
            dir      <= 1'b1;
            cnt_ce   <= 1'b0;
            cnt_up   <= 1'b1;
            cnt_sclr <= 1'b0;
            count    <= 8'd0;
            tick     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cnt_ce   <= 1'b0;
            cnt_sclr <= 1'b0;
            tick     <= 1'b0;
            err      <= 1'b0;
            // shadow mirrors whatever was driven onto the counter pins last cycle
            if (cnt_sclr)
                count <= 8'd0;
            else if (cnt_ce)
                count <= cnt_up ? count + 8'd1 : count - 8'd1;
            case (state)
                IDLE, DONE: if (start && !stop) begin
                    if (hi == 8'd0)
                        err <= 1'b1;
                    else begin
                        state    <= CLR;
                        mode_q   <= mode;
                        hi_q     <= hi;
                        cnt_sclr <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                CLR: if (stop)
                    state <= IDLE;
                else begin
                    state  <= RUN;
                    busy   <= 1'b1;
                    dir    <= 1'b1;
                    cnt_up <= 1'b1;
                    div    <= DW'(TICK_DIV - 1);
                end
                RUN: if (stop) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (fin) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    div  <= (div == '0) ? DW'(TICK_DIV - 1) : div - DW'(1);
                    tick <= div == DW'(1);
                    if (tick && !hold) begin
                        cnt_ce   <= !wrap;
                        cnt_sclr <= wrap;
                        cnt_up   <= next_dir;
                        dir      <= next_dir;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: vector table for command handling, per-tick step checks against an expected
// count sequence built from the mode rules, randomized runs, stop and mid-run reset corners.
module tb_count_ctrl;
    localparam int TD = 4;
`ifdef COUNT_CTRL_DWELL_EN
    localparam bit DWELL = 1'b1;
`else
    localparam bit DWELL = 1'b0;
`endif

    logic       clk_5MHz = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] hi = 8'd0;
    logic       cnt_ce, cnt_up, cnt_sclr, tick, busy, done, err;
    logic [7:0] count;
    int         n_chk = 0;
    int         n_pass = 0;
    int         cycle_no = 0;
    int         exp_q[$];

    count_ctrl #(.TICK_DIV(TD)) dut (
        .clk_5MHz(clk_5MHz), .reset(reset), .start(start), .stop(stop), .mode(mode), .hi(hi),
        .cnt_ce(cnt_ce), .cnt_up(cnt_up), .cnt_sclr(cnt_sclr), .count(count), .tick(tick),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk_5MHz = ~clk_5MHz;
    always @(posedge clk_5MHz) cycle_no <= cycle_no + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    endtask

    // Counts seen after each tick: one period of the mode's waveform, repeated.
    function automatic void build(input logic [1:0] m, input int h, input int n);
        int per[$];
        exp_q.delete();
        for (int v = 1; v <= h; v++) per.push_back(v);
        if (m == 2'b01) per.push_back(0);
        if (m[1]) begin
            if (DWELL) begin per.push_back(h); per.push_back(h); end
            for (int v = h - 1; v >= 0; v--) per.push_back(v);
            if (DWELL && m == 2'b10) begin per.push_back(0); per.push_back(0); end
        end
        for (int i = 0; i < n; i++) exp_q.push_back(per[i % per.size()]);
    endfunction

    function automatic int full_len(input logic [1:0] m, input int h);
        return (m == 2'b00) ? h : 2 * h + (DWELL ? 2 : 0);
    endfunction

    task automatic quiet(input string nm, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_5MHz);
            seen += int'(cnt_ce | cnt_sclr);
        end
        chk(nm, seen, 0);
    endtask

    task automatic run_check(input logic [1:0] m, input int h, input int n, input bit fin);
        int prev = 0;
        int clr_cyc, guard, nv;
        bit sc, stepped;
        build(m, h, n);
        start = 1'b1; mode = m; hi = 8'(h);
        @(negedge clk_5MHz);
        chk("clr_sclr", cnt_sclr, 1);
        chk("clr_done_low", done, 0);
        clr_cyc = cycle_no;
        start = 1'b0; mode = 2'($urandom); hi = 8'($urandom);
        for (int k = 0; k < n; k++) begin
            guard = 0;
            while (!tick && guard < 3 * TD) begin
                @(negedge clk_5MHz);
                guard++;
            end
            chk("tick_time", cycle_no, clr_cyc + TD * (k + 1));
            nv = exp_q[k];
            sc = (m == 2'b01) && prev == h && nv == 0;
            stepped = nv != prev && !sc;
            @(negedge clk_5MHz);
            start = 1'($urandom);
            chk("step_sclr", cnt_sclr, sc);
            chk("step_ce", cnt_ce, stepped);
            if (stepped) chk("step_up", cnt_up, nv > prev);
            @(negedge clk_5MHz);
            start = 1'b0;
            chk("count", count, nv);
            chk("busy", busy, !(fin && k == n - 1));
            prev = nv;
        end
        if (fin) begin
            chk("done", done, 1);
            quiet("done_quiet", 3 * TD);
            chk("done_hold_count", count, prev);
        end
    endtask

    task automatic stop_run();
        int last = exp_q[exp_q.size() - 1];
        stop = 1'b1;
        @(negedge clk_5MHz);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        quiet("stop_quiet", 3 * TD);
        chk("stop_count", count, last);
    endtask

    typedef struct {
        string      nm;
        logic       st;
        logic       sp;
        logic [7:0] h;
        logic       e_err;
        logic       e_sclr;
    } vec_t;
    vec_t vt[5];

    initial begin
        int guard;
        logic [1:0] m;
        int h, n;
        bit fin;
        vt[0] = '{"idle_nop",   1'b0, 1'b0, 8'd5, 1'b0, 1'b0};
        vt[1] = '{"hi_zero",    1'b1, 1'b0, 8'd0, 1'b1, 1'b0};
        vt[2] = '{"start_stop", 1'b1, 1'b1, 8'd7, 1'b0, 1'b0};
        vt[3] = '{"stop_only",  1'b0, 1'b1, 8'd3, 1'b0, 1'b0};
        vt[4] = '{"accept",     1'b1, 1'b0, 8'd4, 1'b0, 1'b1};

        repeat (2) @(negedge clk_5MHz);
        chk("rst_outs", {cnt_ce, cnt_up, cnt_sclr, tick, busy, done, err}, 7'b0100000);
        chk("rst_count", count, 0);
        reset = 1'b0;
        @(negedge clk_5MHz);

        foreach (vt[i]) begin
            start = vt[i].st; stop = vt[i].sp; hi = vt[i].h; mode = 2'b00;
            @(negedge clk_5MHz);
            chk({vt[i].nm, "_err"}, err, vt[i].e_err);
            chk({vt[i].nm, "_sclr"}, cnt_sclr, vt[i].e_sclr);
            chk({vt[i].nm, "_busy"}, busy, 0);
            start = 1'b0; stop = 1'b1;
            @(negedge clk_5MHz);
            stop = 1'b0;
            chk({vt[i].nm, "_err_clear"}, err, 0);
            chk({vt[i].nm, "_idle"}, {busy, done, cnt_sclr}, 0);
            @(negedge clk_5MHz);
        end

        run_check(2'b00, 3, 3, 1'b1);
        run_check(2'b01, 2, 6, 1'b0);
        stop_run();
        run_check(2'b10, 2, DWELL ? 9 : 6, 1'b0);
        stop_run();
        run_check(2'b11, 5, 2, 1'b0);
        stop_run();
        run_check(2'b11, 3, full_len(2'b11, 3), 1'b1);

        for (int r = 0; r < 8; r++) begin
            m = 2'($urandom);
            h = 1 + $urandom_range(0, 4);
            fin = m == 2'b00 || m == 2'b11;
            n = fin ? full_len(m, h) : 3 + $urandom_range(0, 8);
            run_check(m, h, n, fin);
            if (!fin) stop_run();
        end

        run_check(2'b01, 4, 2, 1'b0);
        guard = 0;
        while (!tick && guard < 3 * TD) begin
            @(negedge clk_5MHz);
            guard++;
        end
        @(negedge clk_5MHz);
        chk("pre_reset_ce", cnt_ce, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_outs", {cnt_ce, cnt_up, cnt_sclr, tick, busy, done, err}, 7'b0100000);
        chk("async_rst_count", count, 0);
        @(negedge clk_5MHz);
        reset = 1'b0;
        quiet("post_reset_quiet", 2 * TD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
